// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and result signals of the accumulator ALU command sequencer.
// The slave modport is the sequencer; the master modport is the producer/ALU/consumer side.
interface alu_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [3:0]    alu_opcode;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_c;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_err;
  logic [CW-1:0] count;

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_c, res_ready,
    input  cmd_ready, alu_opcode, alu_a, res_valid, res_data, res_err, count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_c, res_ready,
    output cmd_ready, alu_opcode, alu_a, res_valid, res_data, res_err, count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a FIFO, issues one per cycle to the ALU, screens bad opcodes and
// divide-by-zero against a shadow accumulator, and holds each result on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input logic          clk,
  input logic          rst,
  alu_cmd_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [3:0] OpNoop  = 4'd0;
  localparam logic [3:0] OpReset = 4'd1;
  localparam logic [3:0] OpDiv   = 4'd5;
  localparam logic [3:0] OpLast  = 4'd9;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e        state_q, state_d;
  logic [3:0]    op_q   [DEPTH];
  logic [W-1:0]  data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic          res_valid_q, res_valid_d;
  logic          res_err_q, res_err_d;

  logic          cmd_ready;
  logic          push, pop, head_err;
  logic [3:0]    head_op;
  logic [W-1:0]  head_data;
  logic [3:0]    alu_opcode;
  logic [W-1:0]  alu_a;

  // Ready depends only on registered state: a full FIFO never accepts, even when popping.
  assign cmd_ready = (state_q == StRun) && (count_q < DepthCnt);
  assign push      = bus.cmd_valid && cmd_ready;
  assign pop       = (state_q == StRun) && (count_q != '0) && (!res_valid_q || bus.res_ready);
  assign head_op   = op_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign head_err  = (head_op > OpLast) || ((head_op == OpDiv) && (shadow_q == '0));

  // ALU drive: clear in INIT, head command on a clean issue, NOOP otherwise.
  always_comb begin
    alu_opcode = OpNoop;
    alu_a      = '0;
    state_d    = state_q;
    unique case (state_q)
      StInit: begin
        alu_opcode = OpReset;
        state_d    = StRun;
      end
      StRun: begin
        if (pop && !head_err) begin
          alu_opcode = head_op;
          alu_a      = head_data;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    shadow_d    = shadow_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    if (state_q == StInit) begin
      shadow_d = '0;
    end else if (pop) begin
      res_valid_d = 1'b1;
      if (head_err) begin
        res_err_d  = 1'b1;
        res_data_d = shadow_q;
      end else begin
        res_err_d  = 1'b0;
        res_data_d = bus.alu_c;
        shadow_d   = bus.alu_c;
      end
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      shadow_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      op_q[wr_ptr_q]   <= bus.cmd_op;
      data_q[wr_ptr_q] <= bus.cmd_data;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.alu_opcode = alu_opcode;
  assign bus.alu_a      = alu_a;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_err    = res_err_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an accumulator ALU model and a result scoreboard.
module tb_alu_cmd_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 16;

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DEPTH(DEPTH), .W(W)) bus ();

  alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           last_acc_cyc = 0;
  int           first_acc;
  logic [W-1:0] alu_acc = '0;
  logic [W-1:0] ref_acc = '0;
  res_t         sb_q[$];
  int           pop_cyc[$];

  // ALU: C = A op ACC, truncated to W bits.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] acc);
    logic [W-1:0] r;
    case (op)
      4'd1:    r = '0;
      4'd2:    r = a + acc;
      4'd3:    r = a - acc;
      4'd4:    r = a * acc;
      4'd5:    r = (acc != '0) ? a / acc : '0;
      4'd6:    r = a & acc;
      4'd7:    r = a | acc;
      4'd8:    r = ~a;
      4'd9:    r = a ^ acc;
      default: r = acc;
    endcase
    return r;
  endfunction

  assign bus.alu_c = alu_fn(bus.alu_opcode, bus.alu_a, alu_acc);
  always @(posedge clk) alu_acc <= bus.alu_c;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result monitor: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && bus.res_valid && bus.res_ready) begin
      pop_cyc.push_back(cyc);
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        res_t e;
        e = sb_q.pop_front();
        chk("res_data", 32'(bus.res_data), 32'(e.data));
        chk("res_err", 32'(bus.res_err), 32'(e.err));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the command is accepted.
  task automatic push(input logic [3:0] op, input logic [W-1:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 50);
    chk("push_accept", 32'(bus.cmd_ready), 32'd1);
    if (bus.cmd_ready) begin
      if (op > 4'd9 || (op == 4'd5 && ref_acc == '0)) begin
        sb_q.push_back('{err: 1'b1, data: ref_acc});
      end else begin
        ref_acc = alu_fn(op, d, ref_acc);
        sb_q.push_back('{err: 1'b0, data: ref_acc});
      end
    end
    @(posedge clk);
    #1;
    last_acc_cyc  = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b1;

    // Reset and INIT.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_opcode", 32'(bus.alu_opcode), 32'h1);
    chk("rst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_res_data", 32'(bus.res_data), 32'h0);
    chk("rst_res_err", 32'(bus.res_err), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("init_opcode", 32'(bus.alu_opcode), 32'h1);
    chk("init_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("run_opcode", 32'(bus.alu_opcode), 32'h0);
    chk("run_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("run_res_valid", 32'(bus.res_valid), 32'h0);
    @(posedge clk);
    #1;

    // Back-to-back: ADD 3, SUB 1, MULT 15 -> 0003, FFFE, FFE2.
    pop_cyc.delete();
    push(4'd2, 16'd3);
    first_acc = last_acc_cyc;
    push(4'd3, 16'd1);
    push(4'd4, 16'd15);
    wait_drain();
    chk("b2b_npop", 32'(pop_cyc.size()), 32'd3);
    chk("b2b_first_lat", 32'(pop_cyc[0]), 32'(first_acc + 1));
    chk("b2b_last_lat", 32'(pop_cyc[2]), 32'(first_acc + 3));

    // Backpressure: 5 accepted, 1 issued and held, 4 queued, 6th stalls.
    bus.res_ready = 1'b0;
    pop_cyc.delete();
    push(4'd2, 16'd10);
    push(4'd9, 16'h00FF);
    push(4'd7, 16'h0F00);
    push(4'd8, 16'h1234);
    push(4'd6, 16'h0FF0);
    @(negedge clk);
    chk("bp_count", 32'(bus.count), 32'd4);
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("bp_opcode", 32'(bus.alu_opcode), 32'h0);
    chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
    chk("bp_held_data", 32'(bus.res_data), 32'(sb_q[0].data));
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd3;
    bus.cmd_data  = 16'd5;
    repeat (3) @(negedge clk);
    chk("bp_stall_ready", 32'(bus.cmd_ready), 32'd0);
    chk("bp_stall_count", 32'(bus.count), 32'd4);
    chk("bp_stable_data", 32'(bus.res_data), 32'(sb_q[0].data));
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    push(4'd3, 16'd5);
    wait_drain();
    chk("bp_npop", 32'(pop_cyc.size()), 32'd6);
    chk("bp_drain_rate", 32'(pop_cyc[5] - pop_cyc[0]), 32'd5);

    // Screening: RESET, DIV 7 (acc 0), opcode 12, ADD 4.
    push(4'd1, 16'd0);
    push(4'd5, 16'd7);
    chk("div0_opcode", 32'(bus.alu_opcode), 32'h0);
    chk("div0_alu_a", 32'(bus.alu_a), 32'h0);
    push(4'hC, 16'd0);
    chk("illegal_opcode", 32'(bus.alu_opcode), 32'h0);
    push(4'd2, 16'd4);
    chk("add_opcode", 32'(bus.alu_opcode), 32'h2);
    chk("add_alu_a", 32'(bus.alu_a), 32'h4);
    wait_drain();

    // Mid-drain reset with one held result and three queued.
    bus.res_ready = 1'b0;
    push(4'd2, 16'd1);
    push(4'd2, 16'd2);
    push(4'd2, 16'd3);
    push(4'd2, 16'd4);
    @(negedge clk);
    chk("md_count", 32'(bus.count), 32'd3);
    chk("md_res_valid", 32'(bus.res_valid), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("md_rst_count", 32'(bus.count), 32'd0);
    chk("md_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("md_rst_res_data", 32'(bus.res_data), 32'd0);
    chk("md_rst_res_err", 32'(bus.res_err), 32'd0);
    chk("md_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("md_rst_opcode", 32'(bus.alu_opcode), 32'h1);
    sb_q.delete();
    ref_acc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("md_init_opcode", 32'(bus.alu_opcode), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("md_run_opcode", 32'(bus.alu_opcode), 32'h0);
    chk("md_run_count", 32'(bus.count), 32'd0);
    chk("md_run_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("md_no_stale", 32'(bus.res_valid), 32'd0);
    @(posedge clk);
    #1;
    push(4'd2, 16'd9);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
